irq_arbiter: RTL and testbench

Interrupt request arbiter placed directly upstream of the processor's interrupt input. It edge-detects several external interrupt sources, latches them as pending, and selects the highest-priority unmasked source. It drives the processor's `int_flag` and consumes the processor's `ack` and an end-of-interrupt pulse (`eoi`, issued when RTI retires). It guarantees one interrupt in flight at a time and recovers if `ack` never arrives.

---
 rtl/irq_arbiter_if.sv | 27 ++
 rtl/irq_arbiter.sv | 121 ++++++++++++
 tb/tb_irq_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Interrupt arbiter <-> processor/source bundle: request lines, mask, handshake and status.
// The slave modport is the arbiter side; the master modport is the environment side.
interface irq_arbiter_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] irq_mask;
    logic             ack;
    logic             eoi;
    logic             int_flag;
    logic [ID_W-1:0]  int_id;
    logic [N_SRC-1:0] pending;
    logic             in_service;
    logic             timeout_err;

    modport slave (
        input  irq_in, irq_mask, ack, eoi,
        output int_flag, int_id, pending, in_service, timeout_err
    );

    modport master (
        output irq_in, irq_mask, ack, eoi,
        input  int_flag, int_id, pending, in_service, timeout_err
    );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-detecting interrupt arbiter: latches events, dispatches the lowest-index unmasked one.
// Latency: event edge -> pending 1 edge, -> int_flag 2 edges; one interrupt in flight, ack timeout recovers.
// Backpressure: new events while busy are held in pending until the block returns to IDLE.
module irq_arbiter #(
    parameter int N_SRC       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    irq_arbiter_if.slave  bus
);
    localparam int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [N_SRC-1:0] irq_prev;
    logic             armed;
    logic [N_SRC-1:0] pending_q;
    logic             int_flag_q;
    logic [ID_W-1:0]  int_id_q;
    logic             in_service_q;
    logic             timeout_err_q;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] cand;
    logic             cand_vld;
    logic [ID_W-1:0]  cand_id;
    logic             ack_take;
    logic             timed_out;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] pending_nxt;

    // irq_prev is unknown-meaningful right after reset; the first edge only
    // captures the level so a line held high through reset is not an event.
    assign rise = armed ? (bus.irq_in & ~irq_prev) : '0;
    assign cand = pending_q & bus.irq_mask;

    always_comb begin
        cand_vld = |cand;
        cand_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) cand_id = ID_W'(i);
        end
    end

    assign ack_take  = (state == S_REQ) && bus.ack;
    assign timed_out = (state == S_REQ) && !bus.ack && (cnt == CNT_LAST);
    assign ack_clr   = ack_take ? (N_SRC'(1) << int_id_q) : '0;
    // A new edge on the bit being acknowledged must survive the clear.
    assign pending_nxt = (pending_q & ~ack_clr) | rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev  <= '0;
            armed     <= 1'b0;
            pending_q <= '0;
        end else begin
            irq_prev  <= bus.irq_in;
            armed     <= 1'b1;
            pending_q <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            int_flag_q    <= 1'b0;
            int_id_q      <= '0;
            in_service_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cand_vld) begin
                        state      <= S_REQ;
                        int_id_q   <= cand_id;
                        int_flag_q <= 1'b1;
                        cnt        <= '0;
                    end
                end
                S_REQ: begin
                    if (ack_take) begin
                        state        <= S_SERVICE;
                        int_flag_q   <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (timed_out) begin
                        // Abandon the request; the source stays pending and retries.
                        state         <= S_IDLE;
                        int_flag_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (bus.eoi) begin
                        state        <= S_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    int_flag_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_flag    = int_flag_q;
    assign bus.int_id      = int_id_q;
    assign bus.pending     = pending_q;
    assign bus.in_service  = in_service_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized + directed bench for irq_arbiter against a behavioural model of the dispatch rules.
module tb_irq_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    irq_arbiter_if #(.N_SRC(N)) bus ();

    irq_arbiter #(.N_SRC(N), .ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    // Model: phase 0 = nothing outstanding, 1 = flag raised awaiting ack, 2 = awaiting eoi.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_prev;
    bit         m_prev_ok;
    int         m_phase;
    int         m_age;
    int         m_id;
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_prev = '0; m_prev_ok = 0;
            m_phase = 0; m_age = 0; m_id = 0; m_err = 0;
        end else begin
            bit [N-1:0] new_ev;
            new_ev = m_prev_ok ? (bus.irq_in & ~m_prev) : '0;
            if (m_phase == 0) begin
                bit found;
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i] && bus.irq_mask[i]) begin
                        found = 1; m_id = i;
                    end
                end
                if (found) begin m_phase = 1; m_age = 1; end
            end else if (m_phase == 1) begin
                if (bus.ack) begin
                    m_phase = 2; m_pend[m_id] = 1'b0;
                end else if (m_age == TO) begin
                    m_phase = 0; m_err = 1;
                end else begin
                    m_age++;
                end
            end else if (bus.eoi) begin
                m_phase = 0;
            end
            m_pend    = m_pend | new_ev;
            m_prev    = bus.irq_in;
            m_prev_ok = 1;
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("cmp_int_flag",    bus.int_flag,    32'(m_phase == 1));
            chk("cmp_int_id",      bus.int_id,      32'(m_id));
            chk("cmp_pending",     bus.pending,     32'(m_pend));
            chk("cmp_in_service",  bus.in_service,  32'(m_phase == 2));
            chk("cmp_timeout_err", bus.timeout_err, 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_flag"}, bus.int_flag, 0);
        chk({tag, "_id"}, bus.int_id, 0);
        chk({tag, "_pend"}, bus.pending, 0);
        chk({tag, "_insvc"}, bus.in_service, 0);
        chk({tag, "_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        bus.irq_in = '0; bus.irq_mask = 4'hF; bus.ack = 0; bus.eoi = 0;
        repeat (2) cyc();
        outputs_zero("reset");
        reset = 1; check_on = 1;
        repeat (2) cyc();

        // Single event on source 2
        bus.irq_in = 4'b0100; cyc();
        chk("single_pend", bus.pending, 4'b0100);
        chk("single_noflag", bus.int_flag, 0);
        cyc();
        chk("single_flag", bus.int_flag, 1);
        chk("single_id", bus.int_id, 2);
        cyc();
        bus.ack = 1; cyc(); bus.ack = 0;
        chk("ack_flag", bus.int_flag, 0);
        chk("ack_pend", bus.pending, 0);
        chk("ack_insvc", bus.in_service, 1);
        bus.irq_in = 0; repeat (2) cyc();
        bus.eoi = 1; cyc(); bus.eoi = 0;
        chk("eoi_insvc", bus.in_service, 0);

        // Priority: sources 1 and 3 together
        bus.irq_in = 4'b1010; cyc();
        chk("prio_pend", bus.pending, 4'b1010);
        cyc();
        chk("prio_first", bus.int_id, 1);
        bus.ack = 1; cyc(); bus.ack = 0;
        chk("prio_pend_left", bus.pending, 4'b1000);
        bus.eoi = 1; cyc(); bus.eoi = 0;
        chk("prio_idle_flag", bus.int_flag, 0);
        cyc();
        chk("prio_second_flag", bus.int_flag, 1);
        chk("prio_second_id", bus.int_id, 3);
        bus.ack = 1; cyc(); bus.ack = 0;
        bus.eoi = 1; cyc(); bus.eoi = 0;
        bus.irq_in = 0; cyc();

        // Masked source 0, then unmask
        bus.irq_mask = 4'b1110; bus.irq_in = 4'b0001; repeat (2) cyc();
        chk("mask_pend", bus.pending, 4'b0001);
        chk("mask_noflag", bus.int_flag, 0);
        bus.irq_mask = 4'hF; cyc();
        chk("unmask_flag", bus.int_flag, 1);
        chk("unmask_id", bus.int_id, 0);

        // Ack timeout: flag high 4 cycles, then low 1, then retry
        repeat (3) cyc();
        chk("to_still_high", bus.int_flag, 1);
        cyc();
        chk("to_flag_low", bus.int_flag, 0);
        chk("to_err", bus.timeout_err, 1);
        chk("to_pend_kept", bus.pending, 4'b0001);
        cyc();
        chk("to_retry", bus.int_flag, 1);
        bus.ack = 1; cyc(); bus.ack = 0;
        bus.eoi = 1; cyc(); bus.eoi = 0;
        bus.irq_in = 0; cyc();

        // Event during service
        bus.irq_in = 4'b0001; repeat (2) cyc();
        bus.ack = 1; cyc(); bus.ack = 0;
        bus.irq_in = 4'b0101; cyc();
        chk("svc_ev_pend", bus.pending, 4'b0100);
        chk("svc_ev_noflag", bus.int_flag, 0);
        chk("svc_ev_insvc", bus.in_service, 1);
        bus.eoi = 1; cyc(); bus.eoi = 0;
        chk("svc_ev_idle", bus.int_flag, 0);
        cyc();
        chk("svc_ev_flag", bus.int_flag, 1);
        chk("svc_ev_id", bus.int_id, 2);

        // Asynchronous reset while requesting
        #2 reset = 0;
        #1 outputs_zero("async_rst");
        @(posedge clk); #1 reset = 1;
        repeat (3) cyc();
        chk("held_no_flag", bus.int_flag, 0);
        chk("held_no_pend", bus.pending, 0);
        bus.irq_in = 4'b0100; cyc();
        bus.irq_in = 4'b0000; cyc();
        bus.irq_in = 4'b0100; repeat (2) cyc();
        chk("retoggle_flag", bus.int_flag, 1);
        chk("retoggle_id", bus.int_id, 2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.irq_in[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) bus.irq_mask = 4'($urandom);
            bus.ack = ($urandom_range(0, 3) == 0);
            bus.eoi = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 0;
                @(posedge clk); #1 reset = 1;
            end
            cyc();
        end
        bus.ack = 0; bus.eoi = 0;
        cyc();
        check_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
